alien_sprite_drawer: RTL
========================

# alien_sprite_drawer

Per-alien pixel generator downstream of the alien group drawer. Each time it is released from reset, it latches one alien's center position and color. It then scans the alien's bounding box row by row and reads a 1-bit sprite ROM with one cycle of latency. It emits clipped pixel writes toward the frame-buffer arbiter and raises `done` when the box is finished, which the group drawer consumes as `alien_draw_done`.

## Interface
- `ALIEN_WIDTH`, 40: sprite columns.
- `ALIEN_HEIGHT`, 21: sprite rows.
- `SCREEN_WIDTH`, 640: visible x range.
- `SCREEN_HEIGHT`, 480: visible y range.
- `BACKGROUND_COLOR_NUM`, 0: color value that means erase.

- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; restart request, driven by the group drawer's `alien_draw_reset`.
- `center_x`  in  10  alien center x; sampled only in S_LATCH.
- `center_y`  in  9  alien center y; sampled only in S_LATCH.
- `color`  in  4  draw color; sampled only in S_LATCH.
- `sprite_addr`  out  10  ROM address, equal to row*ALIEN_WIDTH + col.
- `sprite_bit`  in  1  ROM data, valid one cycle after `sprite_addr`.
- `pixel_x`  out  10  write x.
- `pixel_y`  out  9  write y.
- `pixel_color`  out  4  write color.
- `pixel_we`  out  1  write strobe, one pixel per cycle.
- `done`  out  1  high while in S_DONE.

## Operation
- **States:** S_LATCH → S_SCAN → S_FLUSH → S_DONE. S_DONE holds until the next `reset`.
- **`reset`, any state:**
  - Next state is S_LATCH.
  - row, col, `sprite_addr`, `pixel_we`, `done`, `pixel_x`, `pixel_y`, `pixel_color` all go to 0.
  - While `reset` is held, the block stays in S_LATCH and captures nothing.
- **S_LATCH (first cycle with `reset` low):**
  - Capture `center_x`, `center_y`, `color`.
  - Set `erase` = (`color` == `BACKGROUND_COLOR_NUM`).
  - row = col = 0; `sprite_addr` = 0. Go to S_SCAN.
- **S_SCAN, one address per cycle:**
  - Drive `sprite_addr` = row*W + col.
  - col increments each cycle. At col = W-1 it wraps to 0 and row increments.
  - After address (H-1, W-1) has been issued, go to S_FLUSH.
- **Pipeline stage 2 (cycle after each issued address):**
  - x = cx − W/2 + col; y = cy − H/2 + row.
  - Compute x and y as 11-bit signed values. W/2 and H/2 use integer division (20 and 10 with defaults).
  - `pixel_we` = visible AND (`sprite_bit` OR `erase`).
  - visible = 0 ≤ x < `SCREEN_WIDTH` AND 0 ≤ y < `SCREEN_HEIGHT`.
  - `pixel_x`, `pixel_y` = x[9:0], y[8:0]. `pixel_color` = latched color.
  - Erase writes the whole visible box regardless of the ROM. Draw writes only set sprite bits.
  - Clipped pixels are skipped but still cost their cycle, so the timing is fixed.
- **S_FLUSH:** one cycle that retires the last address through stage 2. Then go to S_DONE.
- **S_DONE:** `done` = 1, `pixel_we` = 0. The block ignores `center`/`color` changes, including when those inputs are tri-stated.

## Timing
- Let cycle 0 be the first cycle with `reset` low (S_LATCH).
  - Addresses are issued in cycles 1 .. W*H.
  - Writes can occur in cycles 2 .. W*H+1.
  - `done` first goes high in cycle W*H+2, which is cycle 842 with defaults.
- **Pixel order:** raster order, row-major, top-left first. The pixel for address k appears exactly one cycle after k.
- **Reset values:** every output is 0 while `reset` is high and in the cycle after it.
- **Reset mid-scan:** `pixel_we` is 0 from the cycle after `reset` is sampled high. No stale write survives from the pipeline. The next pass starts cleanly at row 0, col 0.
- **Reset while in S_DONE:** `done` drops in the cycle after `reset` is sampled.
- **Single-cycle `reset` pulse:** a full restart, identical to a long one.
- **Handshake:** the group drawer must hold `center`/`color` valid through cycle 0 only.

## Test plan
- **Centered draw.**
  - Stimulus: center (320,105), color 3, ROM returning all 1s.
  - Required: 840 writes; first (300,95), last (339,115), in raster order; `done` at cycle 842.
- **Sparse sprite.**
  - Stimulus: ROM with a 1 only at addr 0 and addr 839.
  - Required: exactly two writes, (300,95) in cycle 2 and (339,115) in cycle 841.
- **Erase.**
  - Stimulus: color 0, ROM returning all 0s, center (400,110).
  - Required: 840 writes with `pixel_color` 0.
- **Clip left/top.**
  - Stimulus: center (5,3), ROM returning all 1s.
  - Required: only x 0..24 and y 0..13 written (25*14 = 350 writes); no wrapped coordinates; `done` still at cycle 842.
- **Clip right/bottom.**
  - Stimulus: center (630,475), ROM returning all 1s.
  - Required: x 610..639 and y 465..479 written (30*15 = 450 writes).
- **Reset mid-scan.**
  - Stimulus: assert `reset` at cycle 300, release, new center (200,200).
  - Required: `pixel_we` is 0 the cycle after reset is sampled; the next first write is (180,190); `done` arrives 842 cycles after release.

Source files
------------

// File: rtl/alien_sprite_drawer.sv
// Per-alien pixel generator: latches one alien's center/color, scans its bounding
// box through a 1-cycle-latency sprite ROM and emits clipped pixel writes.
module alien_sprite_drawer #(
    parameter int ALIEN_WIDTH          = 40,
    parameter int ALIEN_HEIGHT         = 21,
    parameter int SCREEN_WIDTH         = 640,
    parameter int SCREEN_HEIGHT        = 480,
    parameter int BACKGROUND_COLOR_NUM = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] center_x,
    input  logic [8:0] center_y,
    input  logic [3:0] color,
    output logic [9:0] sprite_addr,
    input  logic       sprite_bit,
    output logic [9:0] pixel_x,
    output logic [8:0] pixel_y,
    output logic [3:0] pixel_color,
    output logic       pixel_we,
    output logic       done
);

    localparam int CW = $clog2(ALIEN_WIDTH);
    localparam int RW = $clog2(ALIEN_HEIGHT);

    typedef enum logic [1:0] {S_LATCH, S_SCAN, S_FLUSH, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [9:0]    r_cx;
    logic [8:0]    r_cy;
    logic [3:0]    r_color;
    logic          r_erase;
    logic [9:0]    r_addr;
    logic          r_s2_valid;
    logic          r_s2_vis;
    logic [9:0]    r_px;
    logic [8:0]    r_py;
    logic          r_done;

    // bit 10 of w_x / w_y is the sign of the 11-bit two's-complement coordinate
    logic [10:0]   w_x;
    logic [10:0]   w_y;
    logic          w_vis;
    logic          w_last;

    always_comb begin
        w_x    = 11'({1'b0, r_cx}) - 11'(ALIEN_WIDTH / 2) + 11'(r_col);
        w_y    = 11'({2'b0, r_cy}) - 11'(ALIEN_HEIGHT / 2) + 11'(r_row);
        w_vis  = !w_x[10] && (w_x < 11'(SCREEN_WIDTH)) &&
                 !w_y[10] && (w_y < 11'(SCREEN_HEIGHT));
        w_last = (r_row == RW'(ALIEN_HEIGHT - 1)) && (r_col == CW'(ALIEN_WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_LATCH;
            r_col      <= '0;
            r_row      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_color    <= '0;
            r_erase    <= 1'b0;
            r_addr     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_vis   <= 1'b0;
            r_px       <= '0;
            r_py       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_s2_valid <= 1'b0;
            case (r_state)
                S_LATCH: begin
                    r_cx    <= center_x;
                    r_cy    <= center_y;
                    r_color <= color;
                    r_erase <= (color == 4'(BACKGROUND_COLOR_NUM));
                    r_row   <= '0;
                    r_col   <= '0;
                    r_addr  <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    // stage 2 pairs these coordinates with next cycle's ROM data
                    r_s2_valid <= 1'b1;
                    r_s2_vis   <= w_vis;
                    r_px       <= w_x[9:0];
                    r_py       <= w_y[8:0];
                    if (w_last) begin
                        r_state <= S_FLUSH;
                    end else begin
                        r_addr <= r_addr + 10'd1;
                        if (r_col == CW'(ALIEN_WIDTH - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: r_state <= S_LATCH;
            endcase
        end
    end

    assign sprite_addr = r_addr;
    assign pixel_x     = r_px;
    assign pixel_y     = r_py;
    assign pixel_color = r_color;
    assign pixel_we    = r_s2_valid && r_s2_vis && (sprite_bit || r_erase);
    assign done        = r_done;

endmodule
